// File: rtl/regfile_pkg.sv
// Shared widths, constants and types for the multi-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_pkg;
    localparam int REGFILE_DW = 32;
    localparam int REGFILE_AW = 5;
    localparam int ZERO_REG   = 0;

    typedef logic [REGFILE_AW-1:0] reg_addr_t;
    typedef logic [REGFILE_DW-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
// Latency: set/clear visible one cycle after the edge; busy_any is combinational from state.
// Backpressure: none; issue and clears are accepted every cycle.
//
// Ports: clk, reset (sync active-high), issue_valid/issue_reg (set), clr_en[1:0]/clr_reg
// (clear, port w at [w*AW +: AW]), busy (vector, bit 0 always 0), busy_any (OR of busy).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int AW = REGFILE_AW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_reg,
    input  logic [1:0]           clr_en,
    input  logic [2*AW-1:0]      clr_reg,
    output logic [(1<<AW)-1:0]   busy,
    output logic                 busy_any
);
    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        for (int w = 0; w < 2; w++) begin
            if (clr_en[w] && (clr_reg[w*AW +: AW] != AW'(ZERO_REG)))
                busy_nxt[clr_reg[w*AW +: AW]] = 1'b0;
        end
        // Issue is applied after clears: a new issue supersedes a completing write.
        if (issue_valid && (issue_reg != AW'(ZERO_REG)))
            busy_nxt[issue_reg] = 1'b1;
        busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    // Masked by reset so status reads clean even before the first reset edge.
    assign busy_any = (|busy) & ~reset;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NR combinational reads, 2 synchronous writes, r0 hardwired to zero.
// Latency: reads 0 cycles; writes visible next cycle (same cycle when REGFILE_BYPASS_EN defined).
// Backpressure: none; all reads/writes accepted every cycle, hazards reported via rbusy.
//
// Ports: clk, reset (sync active-high); regwrite/wreg/wdata (write port w at slice w);
// rreg/rdata/rbusy (read port r at slice r); issue_valid/issue_reg mark a register pending;
// busy_any is the OR of all pending marks.
// Config macro: REGFILE_BYPASS_EN enables write-to-read forwarding and busy masking.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW = REGFILE_DW,
    parameter int AW = REGFILE_AW,
    parameter int NR = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         regwrite,
    input  logic [2*AW-1:0]    wreg,
    input  logic [2*DW-1:0]    wdata,
    input  logic [NR*AW-1:0]   rreg,
    output logic [NR*DW-1:0]   rdata,
    output logic [NR-1:0]      rbusy,
    input  logic               issue_valid,
    input  logic [AW-1:0]      issue_reg,
    output logic               busy_any
);
    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0][DW-1:0] mem;
    logic [DEPTH-1:0]         busy;

    // Port 1 is applied last so it wins a same-address conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '0;
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (regwrite[w] && (wreg[w*AW +: AW] != AW'(ZERO_REG)))
                    mem[wreg[w*AW +: AW]] <= wdata[w*DW +: DW];
            end
        end
    end

    regfile_scoreboard #(.AW(AW)) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .clr_en      (regwrite),
        .clr_reg     (wreg),
        .busy        (busy),
        .busy_any    (busy_any)
    );

    for (genvar r = 0; r < NR; r++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic          rb;

        always_comb begin
            ra = rreg[r*AW +: AW];
            rd = mem[ra];
            rb = busy[ra] & ~reset;
`ifdef REGFILE_BYPASS_EN
            // Later port overrides earlier, matching write priority.
            for (int w = 0; w < 2; w++) begin
                if (regwrite[w] && (wreg[w*AW +: AW] == ra)) begin
                    rd = wdata[w*DW +: DW];
                    rb = 1'b0;
                end
            end
`endif
            if (ra == AW'(ZERO_REG)) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign rdata[r*DW +: DW] = rd;
        assign rbusy[r]          = rb;
    end
endmodule
